// File: rtl/fifo_pixel_packer_if.sv
// Bundles the FIFO read port and the frame-buffer write port of the pixel packer.
// master = packer side, slave = FIFO / frame-buffer side.
interface fifo_pixel_packer_if #(
  parameter int ADDR_W = 15
);
  logic              empy;
  logic [7:0]        datout;
  logic              rd;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_data;
  logic              frame_done;

  modport master (
    input  empy, datout,
    output rd, fb_we, fb_addr, fb_data, frame_done
  );

  modport slave (
    output empy, datout,
    input  rd, fb_we, fb_addr, fb_data, frame_done
  );
endinterface

// File: rtl/fifo_pixel_packer.sv
// Pops byte pairs from the camera FIFO, packs RGB565 -> RGB332 and writes raster-addressed pixels.
// Define PACKER_BYTE_SWAP_EN to treat the first popped byte as the low half of the RGB565 word.
module fifo_pixel_packer #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic                busy,
  fifo_pixel_packer_if.master bus
);

  localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP_HI = 3'd1,
    CAP_HI = 3'd2,
    POP_LO = 3'd3,
    CAP_LO = 3'd4,
    WRITE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        first_q, first_d;
  logic              popped_q, popped_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]        fb_data_q, fb_data_d;
  logic              frame_done_q, frame_done_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_c;
  logic              last_x, last_y;

  function automatic logic [15:0] assemble_565(input logic [7:0] first_byte,
                                               input logic [7:0] second_byte);
`ifdef PACKER_BYTE_SWAP_EN
    return {second_byte, first_byte};
`else
    return {first_byte, second_byte};
`endif
  endfunction

  // Keep the top bits of each colour channel: R[4:2], G[5:3], B[4:3].
  function automatic logic [7:0] rgb565_to_332(input logic [15:0] pix565);
    return {pix565[15:13], pix565[10:8], pix565[4:3]};
  endfunction

  assign last_x = (x_q == X_LAST);
  assign last_y = (y_q == Y_LAST);

  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    frame_done_d = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    rd_c         = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && !bus.empy) state_d = POP_HI;
      end
      POP_HI: begin
        rd_c    = 1'b1;
        state_d = CAP_HI;
      end
      CAP_HI: begin
        // Data is only fresh on the first cycle after the pop; later wait cycles keep it.
        if (popped_q) first_d = bus.datout;
        if (!bus.empy) state_d = POP_LO;
      end
      POP_LO: begin
        rd_c    = 1'b1;
        state_d = CAP_LO;
      end
      CAP_LO: begin
        fb_we_d      = 1'b1;
        fb_addr_d    = addr_q;
        fb_data_d    = rgb565_to_332(assemble_565(first_q, bus.datout));
        frame_done_d = last_x && last_y;
        state_d      = WRITE;
      end
      WRITE: begin
        if (last_x) begin
          x_d = '0;
          if (last_y) begin
            y_d    = '0;
            addr_d = '0;
          end else begin
            y_d    = y_q + Y_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end
        end else begin
          x_d    = x_q + X_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
        state_d = (enable && !bus.empy) ? POP_HI : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign popped_d = rd_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      first_q      <= '0;
      popped_q     <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      frame_done_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      popped_q     <= popped_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      frame_done_q <= frame_done_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
    end
  end

  // A pop must never reach the FIFO while reset is being sampled.
  assign bus.rd         = rd_c && rst;
  assign bus.fb_we      = fb_we_q;
  assign bus.fb_addr    = fb_addr_q;
  assign bus.fb_data    = fb_data_q;
  assign bus.frame_done = frame_done_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_pixel_packer.sv
// Directed bench for fifo_pixel_packer with a byte-FIFO model and a write/pop monitor.
// Reduced frame geometry (20x6, non power of two) keeps the frame-wrap scenario short.
module tb_fifo_pixel_packer;
  localparam int H_RES  = 20;
  localparam int V_RES  = 6;
  localparam int ADDR_W = 15;
  localparam int NPIX   = H_RES * V_RES;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic busy;

  fifo_pixel_packer_if #(.ADDR_W(ADDR_W)) bus ();

  fifo_pixel_packer #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Byte FIFO model: data appears on datout the cycle after rd.
  logic [7:0] mem [0:65535];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.empy = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (bus.rd && (rd_ptr != wr_ptr)) begin
      bus.datout <= mem[rd_ptr[15:0]];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [ADDR_W-1:0] w_addr[$];
  logic [7:0]        w_data[$];
  int                w_cyc[$];
  int                rd_cyc[$];
  int                fd_cnt = 0;
  logic [ADDR_W-1:0] fd_addr = '0;
  logic              fd_we = 1'b0;
  int                rd_empty_viol = 0;
  int                rd_double_viol = 0;
  logic              rd_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.rd) begin
      if (bus.empy) rd_empty_viol++;
      if (rd_prev) rd_double_viol++;
      rd_cyc.push_back(cyc);
    end
    rd_prev = bus.rd;
    if (bus.fb_we) begin
      w_addr.push_back(bus.fb_addr);
      w_data.push_back(bus.fb_data);
      w_cyc.push_back(cyc);
    end
    if (bus.frame_done) begin
      fd_cnt++;
      fd_addr = bus.fb_addr;
      fd_we   = bus.fb_we;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    w_addr.delete();
    w_data.delete();
    w_cyc.delete();
    rd_cyc.delete();
    fd_cnt = 0;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[15:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  function automatic logic [7:0] first_of(input logic [7:0] hi, input logic [7:0] lo);
`ifdef PACKER_BYTE_SWAP_EN
    return lo;
`else
    return hi;
`endif
  endfunction

  function automatic logic [7:0] second_of(input logic [7:0] hi, input logic [7:0] lo);
`ifdef PACKER_BYTE_SWAP_EN
    return hi;
`else
    return lo;
`endif
  endfunction

  task automatic push_pixel(input logic [7:0] hi, input logic [7:0] lo);
    push(first_of(hi, lo));
    push(second_of(hi, lo));
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    clear_log();
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    int k = 0;
    while (w_addr.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    checks++;
    if (w_addr.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d writes, expected %0d", name, w_addr.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    enable = 1'b1;
    push(8'h55);
    tick(3);
    checks += 6;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (bus.rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b expected 0", bus.rd); end
    if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.fb_we); end
    if (bus.fb_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bus.fb_addr); end
    if (bus.fb_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.fb_data); end
    if (rd_cyc.size() != 0) begin errors++; $display("FAIL reset_no_pop: got %0d pops expected 0", rd_cyc.size()); end
    // Drain the byte so later scenarios start with an empty FIFO.
    rd_ptr = wr_ptr;
    enable = 1'b0;
  endtask

  task automatic test_single_pixel();
    do_reset();
    push_pixel(8'hF8, 8'h00);
    enable = 1'b1;
    wait_writes(1, 50, "single");
    tick(4);
    checks += 4;
    if (rd_cyc.size() != 2) begin errors++; $display("FAIL single_rd_count: got %0d expected 2", rd_cyc.size()); end
    if (w_addr.size() != 1) begin errors++; $display("FAIL single_we_count: got %0d expected 1", w_addr.size()); end
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
    if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL single_fd: got %b expected 0", bus.frame_done); end
    if (w_addr.size() == 1 && rd_cyc.size() == 2) begin
      checks += 3;
      if (w_addr[0] !== 15'd0) begin errors++; $display("FAIL single_addr: got %0d expected 0", w_addr[0]); end
      if (w_data[0] !== 8'hE0) begin errors++; $display("FAIL single_data: got %h expected E0", w_data[0]); end
      if (w_cyc[0] - rd_cyc[1] != 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", w_cyc[0] - rd_cyc[1]); end
    end
    checks++;
    if (bus.fb_data !== 8'hE0) begin errors++; $display("FAIL single_hold: got %h expected E0", bus.fb_data); end
    enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [3];
    exp_d = '{8'h1C, 8'h03, 8'hFF};
    do_reset();
    push_pixel(8'h07, 8'hE0);
    push_pixel(8'h00, 8'h1F);
    push_pixel(8'hFF, 8'hFF);
    enable = 1'b1;
    wait_writes(3, 100, "b2b");
    tick(3);
    checks += 2;
    if (w_addr.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", w_addr.size()); end
    if (fd_cnt != 0) begin errors++; $display("FAIL b2b_fd: got %0d expected 0", fd_cnt); end
    if (w_addr.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks += 2;
        if (w_addr[i] !== ADDR_W'(i)) begin errors++; $display("FAIL b2b_addr%0d: got %0d expected %0d", i, w_addr[i], i); end
        if (w_data[i] !== exp_d[i]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, w_data[i], exp_d[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (w_cyc[i] - w_cyc[i-1] != 5) begin errors++; $display("FAIL b2b_spacing%0d: got %0d expected 5", i, w_cyc[i] - w_cyc[i-1]); end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_empty_gap();
    do_reset();
    push(first_of(8'hF8, 8'h00));
    enable = 1'b1;
    tick(3);
    tick(10);
    checks += 3;
    if (rd_cyc.size() != 1) begin errors++; $display("FAIL gap_rd_held: got %0d pops expected 1", rd_cyc.size()); end
    if (w_addr.size() != 0) begin errors++; $display("FAIL gap_no_we: got %0d writes expected 0", w_addr.size()); end
    if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy: got %b expected 1", busy); end
    push(second_of(8'hF8, 8'h00));
    wait_writes(1, 20, "gap");
    if (w_addr.size() == 1) begin
      checks += 2;
      if (w_data[0] !== 8'hE0) begin errors++; $display("FAIL gap_data: got %h expected E0", w_data[0]); end
      if (w_addr[0] !== 15'd0) begin errors++; $display("FAIL gap_addr: got %0d expected 0", w_addr[0]); end
    end
    enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    do_reset();
    push_pixel(8'h07, 8'hE0);
    push_pixel(8'h00, 8'h1F);
    enable = 1'b1;
    tick(4);
    enable = 1'b0;
    tick(20);
    checks += 4;
    if (w_addr.size() != 1) begin errors++; $display("FAIL endrop_we: got %0d writes expected 1", w_addr.size()); end
    if (rd_cyc.size() != 2) begin errors++; $display("FAIL endrop_rd: got %0d pops expected 2", rd_cyc.size()); end
    if (busy !== 1'b0) begin errors++; $display("FAIL endrop_busy: got %b expected 0", busy); end
    if (wr_ptr - rd_ptr != 2) begin errors++; $display("FAIL endrop_fifo: got %0d bytes expected 2", wr_ptr - rd_ptr); end
    if (w_addr.size() == 1) begin
      checks++;
      if (w_data[0] !== 8'h1C) begin errors++; $display("FAIL endrop_data: got %h expected 1C", w_data[0]); end
    end
    enable = 1'b1;
    wait_writes(2, 50, "endrop_resume");
    if (w_addr.size() == 2) begin
      checks += 2;
      if (w_addr[1] !== 15'd1) begin errors++; $display("FAIL endrop_addr1: got %0d expected 1", w_addr[1]); end
      if (w_data[1] !== 8'h03) begin errors++; $display("FAIL endrop_data1: got %h expected 03", w_data[1]); end
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid_pixel();
    do_reset();
    push(8'hFF);
    enable = 1'b1;
    tick(3);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b expected 1", busy); end
    push_pixel(8'h00, 8'h1F);
    rst = 1'b0;
    tick(3);
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    if (rd_cyc.size() != 1) begin errors++; $display("FAIL midrst_no_pop: got %0d pops expected 1", rd_cyc.size()); end
    if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL midrst_we: got %b expected 0", bus.fb_we); end
    rst = 1'b1;
    clear_log();
    wait_writes(1, 50, "midrst");
    if (w_addr.size() == 1) begin
      checks += 2;
      if (w_addr[0] !== 15'd0) begin errors++; $display("FAIL midrst_addr: got %0d expected 0", w_addr[0]); end
      if (w_data[0] !== 8'h03) begin errors++; $display("FAIL midrst_data: got %h expected 03", w_data[0]); end
    end
    enable = 1'b0;
  endtask

  task automatic test_frame_wrap();
    do_reset();
    for (int i = 0; i < NPIX; i++) push_pixel(8'h07, 8'hE0);
    push_pixel(8'h00, 8'h1F);
    enable = 1'b1;
    wait_writes(NPIX + 1, NPIX * 5 + 100, "frame");
    tick(3);
    checks += 3;
    if (fd_cnt != 1) begin errors++; $display("FAIL frame_fd_count: got %0d expected 1", fd_cnt); end
    if (fd_addr !== ADDR_W'(NPIX - 1)) begin errors++; $display("FAIL frame_fd_addr: got %0d expected %0d", fd_addr, NPIX - 1); end
    if (fd_we !== 1'b1) begin errors++; $display("FAIL frame_fd_we: got %b expected 1", fd_we); end
    if (w_addr.size() == NPIX + 1) begin
      checks += 4;
      if (w_addr[H_RES] !== ADDR_W'(H_RES)) begin errors++; $display("FAIL frame_line_wrap: got %0d expected %0d", w_addr[H_RES], H_RES); end
      if (w_addr[NPIX-1] !== ADDR_W'(NPIX - 1)) begin errors++; $display("FAIL frame_last_addr: got %0d expected %0d", w_addr[NPIX-1], NPIX - 1); end
      if (w_addr[NPIX] !== 15'd0) begin errors++; $display("FAIL frame_wrap_addr: got %0d expected 0", w_addr[NPIX]); end
      if (w_data[NPIX] !== 8'h03) begin errors++; $display("FAIL frame_wrap_data: got %h expected 03", w_data[NPIX]); end
    end
    checks += 2;
    if (rd_empty_viol != 0) begin errors++; $display("FAIL rd_while_empty: got %0d expected 0", rd_empty_viol); end
    if (rd_double_viol != 0) begin errors++; $display("FAIL rd_back_to_back: got %0d expected 0", rd_double_viol); end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_empty_gap();
    test_enable_drop();
    test_reset_mid_pixel();
    test_frame_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
